// File: rtl/ysyx_22041071_axi_rd_master_pkg.sv
// Shared encodings for the AXI4 read master.
//   - AXI burst and response codes
//   - FSM state encoding of the read master
package ysyx_22041071_axi_rd_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ysyx_22041071_rdata_align.sv
// Read-data aligner for single narrow reads.
// Ports:
//   i_data   - raw RDATA beat
//   i_offset - byte offset of the request inside the data word
//   i_size   - log2 bytes of the request
//   i_en     - 1: shift the addressed bytes down to bit 0 and zero the rest
//   o_data   - aligned (or unchanged) data
module ysyx_22041071_rdata_align #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]          i_data,
    input  logic [$clog2(DATA_W/8)-1:0] i_offset,
    input  logic [2:0]                 i_size,
    input  logic                       i_en,
    output logic [DATA_W-1:0]          o_data
);

    logic [DATA_W-1:0] w_shift;

    always_comb begin
        w_shift = i_data >> {i_offset, 3'b000};
        o_data  = i_data;
        if (i_en) begin
            // keep the low 2^size bytes of the shifted word, zero-extend
            for (int b = 0; b < DATA_W/8; b++) begin
                o_data[b*8 +: 8] = (b < (1 << i_size)) ? w_shift[b*8 +: 8] : 8'h00;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041071_axi_rd_master.sv
// AXI4 read master: one CPU read request (single or INCR burst) at a time.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   cpu_ar_*, cpu_id/addr/len/size - CPU request (accepted while idle)
//   cpu_r_*               - one-entry beat register towards the CPU
//   err_o, timeout_o      - sticky error / timeout flags, cleared by err_clr
//   axi_ar_*              - AXI read address channel
//   axi_r_*               - AXI read data channel
module ysyx_22041071_axi_rd_master
    import ysyx_22041071_axi_rd_master_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int ID_W        = 4,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_ar_valid,
    output logic              cpu_ar_ready,
    input  logic [ID_W-1:0]   cpu_id,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [LEN_W-1:0]  cpu_len,
    input  logic [2:0]        cpu_size,
    output logic              cpu_r_valid,
    input  logic              cpu_r_ready,
    output logic [DATA_W-1:0] cpu_r_data,
    output logic [1:0]        cpu_r_resp,
    output logic              cpu_r_last,
    output logic              err_o,
    output logic              timeout_o,
    input  logic              err_clr,
    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ID_W-1:0]   axi_ar_id_o,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [LEN_W-1:0]  axi_ar_len_o,
    output logic [2:0]        axi_ar_size_o,
    output logic [1:0]        axi_ar_burst_o,
    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [DATA_W-1:0] axi_r_data_i,
    input  logic [1:0]        axi_r_resp_i,
    input  logic              axi_r_last_i,
    input  logic [ID_W-1:0]   axi_r_id_i
);

    localparam int         OFF_W     = $clog2(DATA_W/8);
    localparam int         TO_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] FULL_SIZE = 3'(OFF_W);

    rd_state_e         r_state, w_next;
    logic              r_ar_ready;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len, r_cnt;
    logic [2:0]        r_size;
    logic              r_vld, r_last, r_err;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    logic              w_req_hs, w_ar_hs, w_r_hs, w_cnt_zero, w_id_bad, w_last_bad;
    logic              w_err_set, w_align_en;
    logic [1:0]        w_beat_resp;
    logic [DATA_W-1:0] w_aligned;

    assign w_req_hs    = cpu_ar_valid && r_ar_ready;
    assign w_ar_hs     = axi_ar_valid_o && axi_ar_ready_i;
    assign w_r_hs      = axi_r_valid_i && axi_r_ready_o;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_id_bad    = (axi_r_id_i != r_id);
    assign w_last_bad  = (axi_r_last_i != w_cnt_zero);
    assign w_err_set   = w_r_hs && (axi_r_resp_i[1] || w_id_bad || w_last_bad);
    // a beat with a foreign ID is reported to the CPU as SLVERR
    assign w_beat_resp = (w_id_bad && !axi_r_resp_i[1]) ? AXI_RESP_SLVERR : axi_r_resp_i;
    assign w_align_en  = (r_len == '0) && (r_size < FULL_SIZE);

    ysyx_22041071_rdata_align #(.DATA_W(DATA_W)) u_align (
        .i_data   (axi_r_data_i),
        .i_offset (r_addr[OFF_W-1:0]),
        .i_size   (r_size),
        .i_en     (w_align_en),
        .o_data   (w_aligned)
    );

    always_comb begin
        w_next         = r_state;
        axi_ar_valid_o = 1'b0;
        axi_r_ready_o  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_req_hs) w_next = ST_ADDR;
            ST_ADDR: begin
                axi_ar_valid_o = 1'b1;
                if (axi_ar_ready_i) w_next = ST_DATA;
            end
            ST_DATA: begin
                axi_r_ready_o = !r_vld || cpu_r_ready;
                // leave on the expected last beat or on any RLAST, whichever first
                if (w_r_hs && (w_cnt_zero || axi_r_last_i)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ar_ready <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_cnt      <= '0;
            r_vld      <= 1'b0;
            r_data     <= '0;
            r_resp     <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ar_ready <= (w_next == ST_IDLE);
            if (w_req_hs) begin
                r_id   <= cpu_id;
                r_addr <= cpu_addr;
                r_len  <= cpu_len;
                r_size <= cpu_size;
            end
            if (w_ar_hs)     r_cnt <= r_len;
            else if (w_r_hs) r_cnt <= r_cnt - 1'b1;
            if (w_r_hs) begin
                r_vld  <= 1'b1;
                r_data <= w_aligned;
                r_resp <= w_beat_resp;
                r_last <= w_cnt_zero;
            end else if (cpu_r_ready) begin
                r_vld  <= 1'b0;
            end
            r_err <= w_err_set | (r_err & ~err_clr);
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            logic [TO_W-1:0] r_to_cnt;
            logic            r_timeout;
            logic            w_busy, w_prog, w_hit;
            assign w_busy = (r_state != ST_IDLE);
            assign w_prog = w_ar_hs || w_r_hs;
            assign w_hit  = w_busy && !w_prog && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_to_cnt  <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    // saturates so the flag fires once per stall
                    if (!w_busy || w_prog)                      r_to_cnt <= '0;
                    else if (r_to_cnt != TO_W'(TIMEOUT_CYC))    r_to_cnt <= r_to_cnt + 1'b1;
                    r_timeout <= w_hit | (r_timeout & ~err_clr);
                end
            end
            assign timeout_o = r_timeout;
        end else begin : g_no_timeout
            assign timeout_o = 1'b0;
        end
    endgenerate

    assign cpu_ar_ready   = r_ar_ready;
    assign cpu_r_valid    = r_vld;
    assign cpu_r_data     = r_data;
    assign cpu_r_resp     = r_resp;
    assign cpu_r_last     = r_last;
    assign err_o          = r_err;
    assign axi_ar_id_o    = r_id;
    assign axi_ar_addr_o  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign axi_ar_len_o   = r_len;
    assign axi_ar_size_o  = r_size;
    assign axi_ar_burst_o = AXI_BURST_INCR;  // constant tie-off, only INCR is issued

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_master.sv
module tb_ysyx_22041071_axi_rd_master;
    localparam int DW = 64, AW = 64, IW = 4, LW = 8, TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_ar_valid = 1'b0, cpu_ar_ready;
    logic [IW-1:0] cpu_id = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [LW-1:0] cpu_len = '0;
    logic [2:0]    cpu_size = '0;
    logic          cpu_r_valid, cpu_r_ready = 1'b0;
    logic [DW-1:0] cpu_r_data;
    logic [1:0]    cpu_r_resp;
    logic          cpu_r_last, err_o, timeout_o, err_clr = 1'b0;
    logic          axi_ar_valid_o, axi_ar_ready_i = 1'b0;
    logic [IW-1:0] axi_ar_id_o;
    logic [AW-1:0] axi_ar_addr_o;
    logic [LW-1:0] axi_ar_len_o;
    logic [2:0]    axi_ar_size_o;
    logic [1:0]    axi_ar_burst_o;
    logic          axi_r_valid_i = 1'b0, axi_r_ready_o;
    logic [DW-1:0] axi_r_data_i = '0;
    logic [1:0]    axi_r_resp_i = '0;
    logic          axi_r_last_i = 1'b0;
    logic [IW-1:0] axi_r_id_i = '0;

    int total = 0, bad = 0;

    // slave-side beat table for the current transaction
    logic [63:0]   t_data [16];
    logic [1:0]    t_resp [16];
    logic          t_last [16];
    logic [IW-1:0] t_rid;
    logic [63:0]   last_d;
    logic          dropped;

    always #5 clk = ~clk;

    ysyx_22041071_axi_rd_master #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_ar_valid(cpu_ar_valid), .cpu_ar_ready(cpu_ar_ready), .cpu_id(cpu_id), .cpu_addr(cpu_addr),
        .cpu_len(cpu_len), .cpu_size(cpu_size), .cpu_r_valid(cpu_r_valid), .cpu_r_ready(cpu_r_ready),
        .cpu_r_data(cpu_r_data), .cpu_r_resp(cpu_r_resp), .cpu_r_last(cpu_r_last),
        .err_o(err_o), .timeout_o(timeout_o), .err_clr(err_clr),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_id_o(axi_ar_id_o),
        .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_ar_burst_o(axi_ar_burst_o), .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
        .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i),
        .axi_r_id_i(axi_r_id_i)
    );

    task automatic clear_beats(input logic [IW-1:0] rid);
        for (int i = 0; i < 16; i++) begin
            t_data[i] = {$urandom(), $urandom()};
            t_resp[i] = 2'b00;
            t_last[i] = 1'b0;
        end
        t_rid = rid;
    endtask

    // Drives one complete transaction and checks it against the reference model.
    // rmode: 0 CPU always ready, 1 random ready, 2 hold beat 1 for 3 cycles
    // vmode: 0 slave always valid, 1 random valid/AR delay
    task automatic run_txn(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [2:0] size, input int rmode, input int vmode);
        int n, got, sent, cyc, hold;
        logic exp_err, narrow, exp_rr, r_hs, c_hs, exp_last;
        logic [63:0] exp_d, mask;
        logic [1:0] exp_r;
        // model: delivered beats end at len or at the first RLAST
        n = int'(len) + 1;
        for (int i = 0; i <= int'(len); i++) if (t_last[i]) begin n = i + 1; break; end
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (t_resp[i][1] || (t_rid != id) || (t_last[i] != (i == int'(len)))) exp_err = 1'b1;
        end
        narrow = (len == 0) && (size < 3);
        dropped = 1'b0;

        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        cpu_ar_valid = 1'b1; cpu_id = id; cpu_addr = addr; cpu_len = len; cpu_size = size;
        cyc = 0;
        while (cpu_ar_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk); cpu_ar_valid = 1'b0;
        cyc = 0;
        while (axi_ar_valid_o !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        total++;
        if (axi_ar_valid_o !== 1'b1) begin
            bad++; $display("FAIL ar_valid: got %b want 1 (bound expired)", axi_ar_valid_o);
            return;
        end
        if (vmode != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        total++;
        if ({axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_id_o, axi_ar_burst_o} !==
            {addr & ~64'h7, len, size, id, 2'b01}) begin
            bad++;
            $display("FAIL ar_fields: addr=%h len=%0d size=%0d id=%h burst=%b want addr=%h len=%0d size=%0d id=%h burst=01",
                     axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_id_o, axi_ar_burst_o,
                     addr & ~64'h7, len, size, id);
        end
        axi_ar_ready_i = 1'b1;
        @(negedge clk); axi_ar_ready_i = 1'b0;

        sent = 0; got = 0; cyc = 0; hold = 0;
        while (got < n && cyc < 2000) begin
            if (!axi_r_valid_i && sent < n && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                axi_r_valid_i = 1'b1; axi_r_data_i = t_data[sent]; axi_r_resp_i = t_resp[sent];
                axi_r_last_i = t_last[sent]; axi_r_id_i = t_rid;
            end
            case (rmode)
                0: cpu_r_ready = 1'b1;
                1: cpu_r_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (cpu_r_valid && got == 1 && hold < 3) begin cpu_r_ready = 1'b0; hold++; end
                    else cpu_r_ready = 1'b1;
                end
            endcase
            #1;
            exp_rr = (sent < n) ? (!cpu_r_valid || cpu_r_ready) : 1'b0;
            total++;
            if (axi_r_ready_o !== exp_rr) begin
                bad++; $display("FAIL r_ready: got %b want %b (beat %0d)", axi_r_ready_o, exp_rr, sent);
            end
            if (!axi_r_ready_o && sent < n) dropped = 1'b1;
            r_hs = axi_r_valid_i && axi_r_ready_o;
            c_hs = cpu_r_valid && cpu_r_ready;
            if (c_hs) begin
                if (narrow) begin
                    mask  = (64'd1 << (8 << size)) - 64'd1;
                    exp_d = (t_data[got] >> (addr[2:0] * 8)) & mask;
                end else exp_d = t_data[got];
                exp_r    = t_resp[got][1] ? t_resp[got] : ((t_rid != id) ? 2'b10 : t_resp[got]);
                exp_last = (got == int'(len));
                total++;
                if ({cpu_r_data, cpu_r_resp, cpu_r_last} !== {exp_d, exp_r, exp_last}) begin
                    bad++;
                    $display("FAIL beat%0d: data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                             got, cpu_r_data, cpu_r_resp, cpu_r_last, exp_d, exp_r, exp_last);
                end
                last_d = cpu_r_data;
                got++;
            end
            @(negedge clk);
            cyc++;
            if (r_hs) begin
                sent++;
                axi_r_valid_i = 1'b0;
                if (sent == n) begin
                    total++;
                    if (cpu_ar_ready !== 1'b1) begin
                        bad++; $display("FAIL ar_ready_after_last: got %b want 1", cpu_ar_ready);
                    end
                end
            end
        end
        axi_r_valid_i = 1'b0; cpu_r_ready = 1'b0;
        total++;
        if (got != n) begin bad++; $display("FAIL beat_count: got %0d want %0d (bound expired)", got, n); end
        total++;
        if (err_o !== exp_err) begin bad++; $display("FAIL err_o: got %b want %b", err_o, exp_err); end
    endtask

    task automatic test_reset();
        logic [151:0] v;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        v = {cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp, cpu_r_last, err_o, timeout_o, axi_ar_valid_o,
             axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_r_ready_o};
        total++;
        if (v !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", v); end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_ar_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cpu_ar_ready); end
    endtask

    task automatic test_single_aligned();
        clear_beats(4'h1);
        t_data[0] = 64'h1122334455667788; t_last[0] = 1'b1;
        run_txn(4'h1, 64'h8000_0000, 8'd0, 3'd3, 0, 0);
        total++;
        if (last_d !== 64'h1122334455667788) begin
            bad++; $display("FAIL single_data: got %h want 1122334455667788", last_d);
        end
    endtask

    task automatic test_narrow();
        clear_beats(4'h2);
        t_data[0] = 64'h1122334455667788; t_last[0] = 1'b1;
        run_txn(4'h2, 64'h8000_0005, 8'd0, 3'd0, 0, 0);
        total++;
        if (last_d !== 64'h33) begin bad++; $display("FAIL narrow_data: got %h want 33", last_d); end
    endtask

    task automatic test_burst_backpressure();
        clear_beats(4'h4);
        t_last[3] = 1'b1;
        run_txn(4'h4, 64'h8000_0100, 8'd3, 3'd3, 2, 0);
        total++;
        if (dropped !== 1'b1) begin bad++; $display("FAIL r_ready_drop: got %b want 1", dropped); end
    endtask

    task automatic test_early_rlast();
        clear_beats(4'h5);
        t_last[2] = 1'b1;
        run_txn(4'h5, 64'h8000_0200, 8'd3, 3'd3, 0, 0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL err_clr: got %b want 0", err_o); end
    endtask

    task automatic test_slverr_idbad();
        clear_beats(4'h6);
        t_resp[1] = 2'b10; t_last[1] = 1'b1;
        run_txn(4'h6, 64'h8000_0300, 8'd1, 3'd3, 0, 0);
        clear_beats(4'h8);
        t_last[0] = 1'b1;
        run_txn(4'h7, 64'h8000_0400, 8'd0, 3'd3, 1, 1);
    endtask

    task automatic test_random();
        logic [LW-1:0] len;
        logic [2:0] size;
        logic [IW-1:0] id;
        int sel;
        for (int t = 0; t < 40; t++) begin
            len  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
            size = 3'($urandom_range(0, 3));
            id   = 4'($urandom_range(0, 15));
            clear_beats(id);
            t_last[len] = 1'b1;
            for (int i = 0; i <= int'(len); i++) if ($urandom_range(0, 9) == 0) t_resp[i] = 2'($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            if (sel == 0 && len > 0) t_last[$urandom_range(0, int'(len) - 1)] = 1'b1;
            else if (sel == 1) t_last[len] = 1'b0;
            else if (sel == 2) t_rid = id ^ 4'h1;
            run_txn(id, {$urandom(), $urandom()}, len, size, 1, 1);
        end
    endtask

    task automatic test_timeout_reset();
        int k;
        logic [151:0] v;
        @(negedge clk);
        cpu_ar_valid = 1'b1; cpu_id = 4'h3; cpu_addr = 64'h1000; cpu_len = 8'd3; cpu_size = 3'd3;
        k = 0;
        while (cpu_ar_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk); cpu_ar_valid = 1'b0;
        for (k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) begin
                total++;
                if (timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout_o); end
            end
        end
        total++;
        if ({timeout_o, axi_ar_valid_o} !== 2'b11) begin
            bad++; $display("FAIL timeout_set: timeout=%b ar_valid=%b want 1 1", timeout_o, axi_ar_valid_o);
        end
        axi_ar_ready_i = 1'b1;
        @(negedge clk); axi_ar_ready_i = 1'b0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total++;
        if (timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clr: got %b want 0", timeout_o); end
        cpu_r_ready = 1'b0;
        axi_r_valid_i = 1'b1; axi_r_data_i = 64'hDEAD_BEEF_0000_0001; axi_r_resp_i = 2'b00;
        axi_r_last_i = 1'b0; axi_r_id_i = 4'h3;
        @(negedge clk); axi_r_valid_i = 1'b0;
        total++;
        if (cpu_r_valid !== 1'b1) begin bad++; $display("FAIL midburst_valid: got %b want 1", cpu_r_valid); end
        #2 reset_n = 1'b0;
        #1;
        v = {cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp, cpu_r_last, err_o, timeout_o, axi_ar_valid_o,
             axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_r_ready_o};
        total++;
        if (v !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", v); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({cpu_ar_ready, cpu_r_valid, axi_r_ready_o, axi_ar_valid_o} !== 4'b1000) begin
            bad++; $display("FAIL post_reset: got %b want 1000", {cpu_ar_ready, cpu_r_valid, axi_r_ready_o, axi_ar_valid_o});
        end
    endtask

    initial begin
        test_reset();
        test_single_aligned();
        test_narrow();
        test_burst_backpressure();
        test_early_rlast();
        test_slverr_idbad();
        test_random();
        test_timeout_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_axi_rd_master.md
Name: ysyx_22041071_axi_rd_master

Overview:
Parametrised AXI4 read master; successor to the single-beat read channel used by the CPU's I/D memory ports.
- Accepts one CPU read request (single or INCR burst) and issues AR.
- Counts R beats and checks RLAST against the requested length.
- Returns beats to the CPU through a one-entry output register with CPU-side backpressure.
- Single-beat narrow reads are aligned to bit 0 and zero-extended. AXI errors, protocol violations and timeouts are flagged.

Parameters:
DATA_W, 64, AXI/CPU data width in bits; power of two, 32..256
ADDR_W, 64, address width
ID_W, 4, AXI ID width
LEN_W, 8, AXI AxLEN width
TIMEOUT_CYC, 1024, cycles without progress before timeout flag; 0 disables the timeout

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cpu_ar_valid  in  1  CPU request valid
cpu_ar_ready  out  1  request accepted (IDLE only)
cpu_id  in  ID_W  transaction ID
cpu_addr  in  ADDR_W  byte address
cpu_len  in  LEN_W  beats-1
cpu_size  in  3  log2 bytes per beat, must be <= log2(DATA_W/8)
cpu_r_valid  out  1  beat valid to CPU
cpu_r_ready  in  1  CPU accepts beat
cpu_r_data  out  DATA_W  beat data (aligned if single narrow)
cpu_r_resp  out  2  beat RRESP
cpu_r_last  out  1  final beat
err_o  out  1  sticky: SLVERR/DECERR, ID mismatch, or RLAST mismatch
timeout_o  out  1  sticky timeout
err_clr  in  1  clears err_o and timeout_o
axi_ar_valid_o  out  1  AR valid
axi_ar_ready_i  in  1  AR ready
axi_ar_id_o  out  ID_W  ARID
axi_ar_addr_o  out  ADDR_W  ARADDR, aligned to DATA_W/8
axi_ar_len_o  out  LEN_W  ARLEN
axi_ar_size_o  out  3  ARSIZE
axi_ar_burst_o  out  2  ARBURST, always INCR (2'b01)
axi_r_valid_i  in  1  R valid
axi_r_ready_o  out  1  R ready
axi_r_data_i  in  DATA_W  RDATA
axi_r_resp_i  in  2  RRESP
axi_r_last_i  in  1  RLAST
axi_r_id_i  in  ID_W  RID

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; beat counter, timeout counter and error flags 0.
- States:
  - IDLE: cpu_ar_ready=1. On cpu_ar_valid, latch id/addr/len/size into registers and go to ADDR.
  - ADDR: axi_ar_valid_o=1, driven from registered fields; AR fields are stable while valid. On axi_ar_ready_i, go to DATA. The beat counter is loaded with len.
  - DATA: axi_r_ready_o = !cpu_r_valid || cpu_r_ready. Each R handshake loads the output register (cpu_r_valid=1 next cycle) and decrements the counter. The handshake with counter==0 (expected last) goes to IDLE, as does any handshake with RLAST=1.
- Earliest next request: cpu_ar_ready returns the cycle after the final R handshake. The output register may still hold the last beat then; a new AR may issue meanwhile.
- cpu_r_valid is held with data stable until cpu_r_ready. Same-cycle pop and push is allowed; there are no bubbles at full throughput.
- cpu_r_last is the registered (counter==0), not the raw RLAST.
- Alignment: when len==0 and size < log2(DATA_W/8):
  - data = RDATA >> (addr[offset bits]*8), masked to 2^size bytes, zero-extended.
  - otherwise RDATA is passed unchanged.
- Error flags:
  - RRESP[1]=1 on a beat: err_o is set, and that beat's cpu_r_resp carries RRESP.
  - RID != latched id: err_o is set; the beat is still delivered.
  - RLAST=1 with counter!=0, or RLAST=0 with counter==0: err_o is set; FSM returns to IDLE on whichever comes first.
- Timeout: the counter increments in ADDR/DATA on each cycle with no handshake and resets on any handshake. Reaching TIMEOUT_CYC sets timeout_o. The transaction is not aborted.
- err_clr: clears both sticky flags. If err_clr and a new error occur in the same cycle, set wins.
- Reset mid-burst: returns immediately to IDLE; in-flight beats are dropped. The system resets slave and master together.

Decomposition:
- Shared package/define: AXI burst/resp encodings (INCR, OKAY, EXOKAY, SLVERR, DECERR) and the FSM state encoding.
- One natural sub-module: ysyx_22041071_rdata_align (combinational shift/mask by offset and size, parametrised by DATA_W). It can be unit-tested alone.

Test Plan:
- Single aligned read: addr 0x8000_0000, len 0, size 3; slave returns 0x1122334455667788 OKAY, RLAST=1 -> ARADDR 0x8000_0000, ARLEN 0, cpu_r_data 0x1122334455667788, cpu_r_last=1, err_o=0.
- Narrow unaligned read: addr 0x8000_0005, size 0, RDATA 0x1122334455667788 -> ARADDR 0x8000_0000, cpu_r_data 0x33.
- 4-beat burst, cpu_r_ready low for 3 cycles on beat 1 -> axi_r_ready_o drops, beats 0..3 delivered in order unchanged, cpu_r_last only on beat 3.
- Early RLAST on beat 2 of len=3 -> err_o=1, FSM in IDLE, cpu_ar_ready=1 next cycle. Then err_clr -> err_o=0.
- SLVERR on beat 1 of 2, and RID mismatch on a single read -> cpu_r_resp=2'b10 on that beat; err_o set in both cases.
- AR ready withheld TIMEOUT_CYC cycles -> timeout_o=1, axi_ar_valid_o still 1. Assert reset_n=0 mid-burst -> all outputs 0 asynchronously.
